sync_edge_detect: RTL and testbench
===================================

SYNC_EDGE_DETECT -- requirements
Module: sync_edge_detect

Interface
- REQ-001 Parameter WIDTH, default 4: number of synchronized signal bits, 1..32.
- REQ-002 Parameter RST_VAL, default 1'b0: reset value of every filtered level bit.
- REQ-003 Parameter FILTER_CYCLES, default 4: consecutive differing samples required before a level change is accepted, 1..255.
- REQ-004 dst_clk  in  1: the only clock; all logic is on its rising edge.
- REQ-005 dst_rst_n  in  1: reset, asynchronous assert, active-low.
- REQ-006 in_sync  in  WIDTH: levels already double-flopped into dst_clk by the upstream synchronizer.
- REQ-007 level_out  out  WIDTH: debounced level.
- REQ-008 rise_pulse / fall_pulse  out  WIDTH each: one-cycle strobes coincident with a level_out transition.
- REQ-009 evt_valid, evt_ready, evt_idx[clog2(WIDTH) bits, min 1], evt_rise: registered event stream (valid/ready); evt_rise=1 rise, 0 fall.
- REQ-010 evt_ovf  out  1: sticky flag for lost events; evt_ovf_clr  in  1 clears it.
- REQ-011 rise_cnt  out  16*WIDTH: per-bit rise counters, bit i at [16i+15:16i]; cnt_clr  in  1.

Function
- REQ-012 Per bit, a filter counter increments while in_sync[i] != level_out[i] and clears when they are equal.
- REQ-013 If in_sync[i] differs from level_out[i] in cycles t..t+FILTER_CYCLES-1, level_out[i] SHALL toggle at the edge ending cycle t+FILTER_CYCLES-1; the counter clears.
- REQ-014 A mismatch shorter than FILTER_CYCLES SHALL leave level_out unchanged; FILTER_CYCLES=1 gives one-cycle latency.
- REQ-015 rise_pulse[i]/fall_pulse[i] SHALL be registered and high exactly during the first cycle of the new level_out[i].
- REQ-016 Each edge sets pend[i] and records its type in pend_rise[i].
- REQ-017 Output slot: loaded when empty, or in the same cycle its event is accepted, from the lowest-indexed pending bit; that pend bit clears on load.
- REQ-018 While evt_valid=1 and evt_ready=0, evt_idx and evt_rise SHALL hold stable; evt_valid never drops without a handshake.
- REQ-019 Minimum latency: level_out edge cycle -> evt_valid the next cycle.
- REQ-020 If an edge arrives on a bit whose pend is set and not being loaded this cycle, pend_rise SHALL be overwritten with the newest type and evt_ovf set.
- REQ-021 An edge arriving in the same cycle its bit's pend is loaded into the slot SHALL re-set pend without overflow.
- REQ-022 Simultaneous edges on several bits are all captured; no overflow.
- REQ-023 evt_ovf_clr and a new overflow in the same cycle: set wins.

Reset
- REQ-024 On dst_rst_n low: level_out={WIDTH{RST_VAL}}, pulses 0, filter counters 0, pend 0, evt_valid 0, evt_idx 0, evt_rise 0, evt_ovf 0, rise_cnt 0.
- REQ-025 Reset mid-operation SHALL discard pending and in-flight events; the first post-reset sample is compared against RST_VAL.

Configuration
- REQ-026 Macro SYNC_EDGE_CNT_EN defined: each rise_cnt lane increments on rise_pulse, wraps 0xFFFF -> 0x0000, and cnt_clr zeroes all lanes, clear winning over a same-cycle rise.
- REQ-027 Macro SYNC_EDGE_CNT_EN undefined: rise_cnt is tied to 0, cnt_clr is ignored, and no counter flops are built.

Structure
- REQ-028 Shared package sync_edge_pkg SHALL hold the counter width (16), the EVT_RISE/EVT_FALL encodings and the index-width function.
- REQ-029 Sub-module sig_glitch_filter (one bit: filter counter, level register, pulses) SHALL be instantiated WIDTH times; pending/arbitration logic stays in the top.

Verification
- REQ-030 FILTER_CYCLES=4, in_sync[0] 0->1 held 4 cycles -> level_out[0] rises after the 4th sample, rise_pulse[0] one cycle, evt_valid next cycle with idx=0, rise=1.
- REQ-031 in_sync[1] high for 3 cycles then low -> no level change, no pulse, no event.
- REQ-032 evt_ready=0, bit 2 rises then falls -> one event held stable; second edge overwrites pend_rise=0, evt_ovf=1; evt_ovf_clr for 1 cycle -> evt_ovf=0.
- REQ-033 Bits 0 and 3 rise in the same cycle, evt_ready=1 -> events idx 0 then idx 3 on consecutive cycles, evt_ovf stays 0.
- REQ-034 With SYNC_EDGE_CNT_EN, 65537 rises on bit 0 -> rise_cnt[15:0]=1; cnt_clr coincident with a rise -> 0.
- REQ-035 dst_rst_n asserted while evt_valid=1 and pend nonzero -> all outputs reach reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/sync_edge_pkg.sv
// sync_edge_pkg: shared widths, event encodings and index-width helper for sync_edge_detect
package sync_edge_pkg;
    localparam int CNT_W = 16;
    localparam int FLT_W = 8;
    localparam logic EVT_RISE = 1'b1;
    localparam logic EVT_FALL = 1'b0;
    function automatic int idx_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction
endpackage

// File: rtl/sig_glitch_filter.sv
// sig_glitch_filter: one-bit debounce with registered level and edge strobes
module sig_glitch_filter
    import sync_edge_pkg::*;
#(
    parameter logic RST_VAL       = 1'b0,
    parameter int   FILTER_CYCLES = 4
) (
    input  logic dst_clk,
    input  logic dst_rst_n,
    input  logic in_sync,
    output logic level_out,
    output logic rise_pulse,
    output logic fall_pulse
);
    logic [FLT_W-1:0] cnt_q, cnt_d;
    logic level_q, level_d, rise_q, rise_d, fall_q, fall_d, diff, fire;
    // The FILTER_CYCLES-th consecutive differing sample flips the level directly
    always_comb begin
        diff    = in_sync != level_q;
        fire    = diff && (cnt_q == FLT_W'(FILTER_CYCLES - 1));
        cnt_d   = (diff && !fire) ? cnt_q + 1'b1 : '0;
        level_d = fire ? in_sync : level_q;
        rise_d  = fire && in_sync;
        fall_d  = fire && !in_sync;
    end
    always_ff @(posedge dst_clk or negedge dst_rst_n) begin
        if (!dst_rst_n) begin
            cnt_q   <= '0;
            level_q <= RST_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end
    assign level_out  = level_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
endmodule

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: debounced levels, edge strobes, event stream; SYNC_EDGE_CNT_EN adds rise counters
module sync_edge_detect
    import sync_edge_pkg::*;
#(
    parameter int   WIDTH         = 4,
    parameter logic RST_VAL       = 1'b0,
    parameter int   FILTER_CYCLES = 4,
    localparam int  IW            = idx_w(WIDTH)
) (
    input  logic                   dst_clk,
    input  logic                   dst_rst_n,
    input  logic [WIDTH-1:0]       in_sync,
    output logic [WIDTH-1:0]       level_out,
    output logic [WIDTH-1:0]       rise_pulse,
    output logic [WIDTH-1:0]       fall_pulse,
    output logic                   evt_valid,
    input  logic                   evt_ready,
    output logic [IW-1:0]          evt_idx,
    output logic                   evt_rise,
    output logic                   evt_ovf,
    input  logic                   evt_ovf_clr,
    output logic [CNT_W*WIDTH-1:0] rise_cnt,
    input  logic                   cnt_clr
);
    for (genvar i = 0; i < WIDTH; i++) begin : g_flt
        sig_glitch_filter #(
            .RST_VAL      (RST_VAL),
            .FILTER_CYCLES(FILTER_CYCLES)
        ) u_flt (
            .dst_clk   (dst_clk),
            .dst_rst_n (dst_rst_n),
            .in_sync   (in_sync[i]),
            .level_out (level_out[i]),
            .rise_pulse(rise_pulse[i]),
            .fall_pulse(fall_pulse[i])
        );
    end
    logic [WIDTH-1:0] edge_v, avail, avail_rise, loaded;
    logic [WIDTH-1:0] pend_q, pend_d, pend_rise_q, pend_rise_d;
    logic [IW-1:0]    sel, evt_idx_q, evt_idx_d;
    logic             load, evt_valid_q, evt_valid_d, evt_rise_q, evt_rise_d, evt_ovf_q, evt_ovf_d;
    // A fresh edge bypasses pend so an empty slot fills the cycle after the strobe
    always_comb begin
        edge_v      = rise_pulse | fall_pulse;
        avail       = pend_q | edge_v;
        avail_rise  = (pend_q & pend_rise_q) | (~pend_q & rise_pulse);
        sel         = '0;
        for (int i = WIDTH - 1; i >= 0; i--)
            if (avail[i]) sel = IW'(i);
        load        = (|avail) && (!evt_valid_q || evt_ready);
        loaded      = load ? (WIDTH'(1) << sel) : '0;
        pend_d      = (pend_q & ~loaded) | (edge_v & ~(loaded & ~pend_q));
        pend_rise_d = (edge_v & rise_pulse) | (~edge_v & pend_rise_q);
        evt_ovf_d   = (|(pend_q & edge_v & ~loaded)) || (evt_ovf_q && !evt_ovf_clr);
        evt_valid_d = load || (evt_valid_q && !evt_ready);
        evt_idx_d   = load ? sel : evt_idx_q;
        evt_rise_d  = load ? (avail_rise[sel] ? EVT_RISE : EVT_FALL) : evt_rise_q;
    end
    always_ff @(posedge dst_clk or negedge dst_rst_n) begin
        if (!dst_rst_n) begin
            pend_q      <= '0;
            pend_rise_q <= '0;
            evt_valid_q <= 1'b0;
            evt_idx_q   <= '0;
            evt_rise_q  <= 1'b0;
            evt_ovf_q   <= 1'b0;
        end else begin
            pend_q      <= pend_d;
            pend_rise_q <= pend_rise_d;
            evt_valid_q <= evt_valid_d;
            evt_idx_q   <= evt_idx_d;
            evt_rise_q  <= evt_rise_d;
            evt_ovf_q   <= evt_ovf_d;
        end
    end
    assign evt_valid = evt_valid_q;
    assign evt_idx   = evt_idx_q;
    assign evt_rise  = evt_rise_q;
    assign evt_ovf   = evt_ovf_q;
`ifdef SYNC_EDGE_CNT_EN
    logic [CNT_W*WIDTH-1:0] cnt_q, cnt_d;
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < WIDTH; i++)
            cnt_d[CNT_W*i +: CNT_W] = cnt_clr ? '0 : cnt_q[CNT_W*i +: CNT_W] + CNT_W'(rise_pulse[i]);
    end
    always_ff @(posedge dst_clk or negedge dst_rst_n) begin
        if (!dst_rst_n) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
    assign rise_cnt = cnt_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign rise_cnt       = '0;
`endif
endmodule

// File: tb/tb_sync_edge_detect.sv
// tb_sync_edge_detect: scoreboard bench for sync_edge_detect (WIDTH=4, FILTER_CYCLES=4)
module tb_sync_edge_detect;
    import sync_edge_pkg::*;
    localparam int WIDTH = 4;
    logic dst_clk = 1'b0, dst_rst_n = 1'b0, evt_ready = 1'b0, evt_ovf_clr = 1'b0, cnt_clr = 1'b0;
    logic [WIDTH-1:0] in_sync = '0, level_out, rise_pulse, fall_pulse;
    logic evt_valid, evt_rise, evt_ovf;
    logic [1:0] evt_idx;
    logic [CNT_W*WIDTH-1:0] rise_cnt, exp_cnt;
    logic [2:0] exp_q[$];
    int n_chk = 0, n_fail = 0;
    always #5 dst_clk = ~dst_clk;
    sync_edge_detect #(.WIDTH(WIDTH), .RST_VAL(1'b0), .FILTER_CYCLES(4)) dut (
        .dst_clk(dst_clk), .dst_rst_n(dst_rst_n), .in_sync(in_sync), .level_out(level_out),
        .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_idx(evt_idx), .evt_rise(evt_rise), .evt_ovf(evt_ovf), .evt_ovf_clr(evt_ovf_clr),
        .rise_cnt(rise_cnt), .cnt_clr(cnt_clr)
    );
    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask
    task automatic cyc(input int n);
        repeat (n) @(negedge dst_clk);
    endtask
    // Every visible event must match the scoreboard head, which also proves stability while stalled
    always begin
        @(negedge dst_clk);
        #1;
        if (dst_rst_n && evt_valid) begin
            if (exp_q.size() == 0) check("evt_spurious_qsize", 64'(exp_q.size()), 1);
            else begin
                check("evt_idx_rise", {evt_idx, evt_rise}, exp_q[0]);
                if (evt_ready) void'(exp_q.pop_front());
            end
        end
    end
    initial begin
        cyc(2);
        check("rst_level", level_out, 0);
        check("rst_pulses", {rise_pulse, fall_pulse}, 0);
        check("rst_evt", {evt_valid, evt_idx, evt_rise, evt_ovf}, 0);
        check("rst_cnt", rise_cnt, 0);
        dst_rst_n = 1'b1;
        evt_ready = 1'b1;
        cyc(1);
        in_sync[0] = 1'b1;
        exp_q.push_back({2'd0, EVT_RISE});
        cyc(3);
        check("flt_l3_level", level_out[0], 0);
        cyc(1);
        check("flt_l4_level", level_out[0], 1);
        check("flt_l4_rise", rise_pulse, 4'b0001);
        check("flt_l4_valid", evt_valid, 0);
        cyc(1);
        check("flt_l5_rise", rise_pulse, 0);
        check("flt_l5_valid", evt_valid, 1);
        cyc(1);
        check("flt_l6_valid", evt_valid, 0);
        in_sync[1] = 1'b1;
        cyc(3);
        in_sync[1] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc(1);
            check("glitch_level", level_out, 4'b0001);
            check("glitch_pulse", {rise_pulse, fall_pulse}, 0);
        end
        evt_ready = 1'b0;
        in_sync[0] = 1'b0;
        exp_q.push_back({2'd0, EVT_FALL});
        cyc(5);
        check("stall_valid", evt_valid, 1);
        in_sync[2] = 1'b1;
        exp_q.push_back({2'd2, EVT_FALL});
        cyc(6);
        check("pend_level", level_out, 4'b0100);
        check("pend_no_ovf", evt_ovf, 0);
        in_sync[2] = 1'b0;
        cyc(6);
        check("ovr_level", level_out, 4'b0000);
        check("ovr_ovf", evt_ovf, 1);
        evt_ovf_clr = 1'b1;
        cyc(1);
        evt_ovf_clr = 1'b0;
        check("ovf_clr", evt_ovf, 0);
        evt_ready = 1'b1;
        cyc(4);
        check("drain_qsize", 64'(exp_q.size()), 0);
        check("drain_valid", evt_valid, 0);
        in_sync = 4'b1001;
        exp_q.push_back({2'd0, EVT_RISE});
        exp_q.push_back({2'd3, EVT_RISE});
        cyc(4);
        check("dual_pulse", rise_pulse, 4'b1001);
        cyc(1);
        check("dual_first", {evt_valid, evt_idx}, {1'b1, 2'd0});
        cyc(1);
        check("dual_second", {evt_valid, evt_idx}, {1'b1, 2'd3});
        cyc(1);
        check("dual_done", {evt_valid, evt_ovf}, 0);
        evt_ready = 1'b0;
        in_sync = 4'b1111;
        exp_q.push_back({2'd1, EVT_RISE});
        cyc(5);
        check("pre_rst_valid", {evt_valid, evt_idx}, {1'b1, 2'd1});
        #3;
        dst_rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("arst_level", level_out, 0);
        check("arst_pulses", {rise_pulse, fall_pulse}, 0);
        check("arst_evt", {evt_valid, evt_idx, evt_rise, evt_ovf}, 0);
        check("arst_cnt", rise_cnt, 0);
        cyc(2);
        dst_rst_n = 1'b1;
        evt_ready = 1'b1;
        for (int b = 0; b < WIDTH; b++) exp_q.push_back({2'(b), EVT_RISE});
        cyc(3);
        check("post_rst_l3", level_out, 0);
        cyc(1);
        check("post_rst_l4", level_out, 4'b1111);
        cyc(6);
        check("post_rst_qsize", 64'(exp_q.size()), 0);
        check("post_rst_ovf", evt_ovf, 0);
`ifdef SYNC_EDGE_CNT_EN
        exp_cnt = {4{16'h0001}};
        check("cnt_lanes", rise_cnt, exp_cnt);
        in_sync[0] = 1'b0;
        exp_q.push_back({2'd0, EVT_FALL});
        cyc(6);
        check("cnt_fall_keeps", rise_cnt, exp_cnt);
        in_sync[0] = 1'b1;
        exp_q.push_back({2'd0, EVT_RISE});
        cyc(4);
        cnt_clr = 1'b1;
        check("cnt_clr_rise", rise_pulse[0], 1);
        cyc(1);
        cnt_clr = 1'b0;
        check("cnt_clr_wins", rise_cnt, 0);
`else
        exp_cnt = '0;
        check("cnt_tied", rise_cnt, exp_cnt);
        cnt_clr = 1'b1;
        cyc(1);
        cnt_clr = 1'b0;
        check("cnt_tied_clr", rise_cnt, exp_cnt);
`endif
        cyc(4);
        check("final_qsize", 64'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
